// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM receiver. Aligns to a slot-0 frame marker and
// publishes one complete frame at a time. Optional macro: TDM_DEMUX4_ERRCNT_EN.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    input  logic             sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [1:0]       sel,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err,
    output logic [7:0]       err_cnt
);

    localparam logic HUNT   = 1'b0;
    localparam logic LOCKED = 1'b1;

    logic             state;
    logic [WIDTH-1:0] shadow [0:2];

    logic start_frame;
    logic early_sync;
    logic missing_sync;
    logic store_slot;
    logic frame_done;
    logic err_event;

    // Any qualified marker starts a new frame, whether hunting, aligned or early.
    always_comb begin
        start_frame  = din_valid && sync;
        early_sync   = din_valid && (state == LOCKED) && sync && (sel != 2'd0);
        missing_sync = din_valid && (state == LOCKED) && !sync && (sel == 2'd0);
        store_slot   = din_valid && (state == LOCKED) && !sync && (sel != 2'd0);
        frame_done   = store_slot && (sel == 2'd3);
        err_event    = early_sync || missing_sync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            sel         <= 2'd0;
            shadow[0]   <= '0;
            shadow[1]   <= '0;
            shadow[2]   <= '0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            sync_err    <= err_event;
            if (start_frame) begin
                shadow[0] <= din;
                sel       <= 2'd1;
                state     <= LOCKED;
            end else if (missing_sync) begin
                sel   <= 2'd0;
                state <= HUNT;
            end else if (frame_done) begin
                // Slot 3 goes straight to d so all four outputs move on one edge.
                a   <= shadow[0];
                b   <= shadow[1];
                c   <= shadow[2];
                d   <= din;
                sel <= 2'd0;
            end else if (store_slot) begin
                case (sel)
                    2'd1:    shadow[1] <= din;
                    default: shadow[2] <= din;
                endcase
                sel <= sel + 2'd1;
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef TDM_DEMUX4_ERRCNT_EN
    logic [7:0] err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err_event && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign err_cnt = err_count;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: the receive-side counterpart of the 4:1 mux, recovering four channels from a single sample stream that a transmitter builds by cycling its select 00→01→10→11. It aligns to a frame-sync marker on slot 0 and collects one sample per slot into a shadow bank. It then updates all four channel outputs atomically once per complete frame. It sits between the serial/TDM link and per-channel logic.

## Interface
- `WIDTH`, default 1: bits per sample and per channel output.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `din_valid`  in  1  `din` carries a sample this cycle.
- `din`  in  WIDTH  sample for the current slot.
- `sync`  in  1  frame marker; qualified by `din_valid`; marks the slot-0 sample.
- `a`, `b`, `c`, `d`  out  WIDTH each  channel outputs for slots 0, 1, 2, 3, registered.
- `sel`  out  2  slot index the next accepted sample will fill.
- `frame_valid`  out  1  one-cycle pulse: `a`..`d` just updated.
- `locked`  out  1  high in LOCKED state.
- `sync_err`  out  1  one-cycle pulse on an alignment error.
- `err_cnt`  out  8  alignment error count (see Configuration).

## Operation
- Accepted sample: a cycle with `din_valid`=1. When `din_valid`=0, all state holds and pulses are 0.
- State HUNT:
  - Samples with `sync`=0 are discarded; `sel` stays 0.
  - Sample with `sync`=1: store into `shadow[0]`, set `sel`=1, go to LOCKED.
- State LOCKED, normal sample (`sync` matches slot): store `din` into `shadow[sel]`, then `sel`←`sel`+1, wrapping 3→0.
- Frame completion, sample accepted at `sel`=3:
  - `a`←`shadow[0]`, `b`←`shadow[1]`, `c`←`shadow[2]`, `d`←`din`, all on the same edge.
  - `frame_valid`=1 for the following cycle.
  - `sel`←0.
- Early sync: `sync`=1 with `sel`≠0.
  - Assert `sync_err` and discard the partial frame; `a`..`d` are unchanged.
  - The sample becomes slot 0: `shadow[0]`←`din`, `sel`←1, remain LOCKED.
- Missing sync: `sync`=0 with `sel`=0 in LOCKED.
  - Assert `sync_err`, discard the sample, `sel` stays 0, go to HUNT.
- Priority: `rst` > `din_valid` gating > sync checks > normal store.
- `a`..`d` only ever change on frame completion or reset; a partial frame never leaks to the outputs.

## Timing
- Reset values:
  - `a`..`d`=0, `sel`=0, `frame_valid`=0, `sync_err`=0, `locked`=0, `err_cnt`=0, state HUNT.
  - The shadow bank is cleared.
- Latency: slot-3 sample accepted at edge N gives `a`..`d` valid and `frame_valid`=1 from edge N until edge N+1.
- Back-to-back frames with `din_valid` held high: `frame_valid` pulses every 4 cycles.
- Gaps inside a frame are allowed; the frame completes on the 4th accepted sample.
- `sync_err` is registered, high for the cycle after the offending sample's edge.
- `locked` rises on the edge that accepts the first sync sample and falls on the edge that detects a missing sync.
- `rst` asserted mid-frame: at the next edge all state returns to reset values and the partial frame is lost.

## Configuration
- Macro `TDM_DEMUX4_ERRCNT_EN`.
- Defined: `err_cnt` increments by 1 on every `sync_err` event and saturates at 255; only `rst` clears it.
- Undefined: the counter logic is absent and `err_cnt` is tied to 8'd0. All other behaviour is identical.

## Test plan
- Reset, then stream (`sync`,`din`): (1,0)(0,1)(0,0)(0,1) with `WIDTH`=1 -> `locked`=1 after the first sample; `a`=0 `b`=1 `c`=0 `d`=1 with a single `frame_valid` pulse.
- Next frame 1,0,1,0 with 2 idle cycles inserted after slot 1 -> `a`..`d` hold 0,1,0,1 until slot 3 is accepted, then become 1,0,1,0; exactly one `frame_valid`.
- Sync asserted on the 3rd sample of a frame -> one `sync_err` pulse, `a`..`d` unchanged, `sel`=1; with the macro defined `err_cnt`=1.
- After a complete frame, the next sample arrives with `sync`=0 -> `sync_err`, `locked`=0; further samples with `sync`=0 produce no `frame_valid`; a sample with `sync`=1 relocks.
- `rst` pulsed after slot 2 -> all outputs 0, state HUNT; a following full frame decodes correctly.
- Macro defined, 300 alignment errors -> `err_cnt`=255; macro undefined -> `err_cnt` stays 0.
